// File: rtl/vga_ram_arbiter.sv
// Shares one single-port text RAM between the CPU Wishbone slave and the VGA fetch engine.
// VGA wins by default; a saturating wait counter forces a CPU slot after MAX_WAIT losses.
module vga_ram_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  input  logic          vga_req_i,
  input  logic [AW-1:0] vga_adr_i,
  output logic          vga_gnt_o,
  output logic [DW-1:0] vga_dat_o,
  output logic          vga_vld_o,
  output logic          ram_cs_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_adr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] W_MAX = WCW'(MAX_WAIT);
  localparam logic [WCW-1:0] W_ONE = WCW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]     r_state;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_vld;
  logic           w_cpu_pend;
  logic           w_cpu_gnt;
  logic           w_vga_gnt;

  // The ACK state blocks a new grant, limiting the CPU to one access per two cycles.
  assign w_cpu_pend = wb_cyc_i & wb_stb_i & (r_state == ST_IDLE);
  assign w_cpu_gnt  = rst_n & w_cpu_pend & (~vga_req_i | (r_wait_cnt == W_MAX));
  assign w_vga_gnt  = rst_n & vga_req_i & ~w_cpu_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_state <= w_cpu_gnt ? ST_ACK : ST_IDLE;
      r_vld   <= w_vga_gnt;
      if (w_cpu_gnt || !w_cpu_pend)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != W_MAX)
        r_wait_cnt <= r_wait_cnt + W_ONE;
    end
  end

  assign vga_gnt_o   = w_vga_gnt;
  assign ram_cs_o    = w_cpu_gnt | w_vga_gnt;
  assign ram_we_o    = w_cpu_gnt & wb_we_i;
  assign ram_adr_o   = w_cpu_gnt ? wb_adr_i : vga_adr_i;
  assign ram_wdata_o = wb_dat_i;

  // RAM output is registered inside the RAM, so read data lines up with ack/vld.
  assign wb_ack_o  = (r_state == ST_ACK);
  assign wb_dat_o  = ram_rdata_i;
  assign vga_vld_o = r_vld;
  assign vga_dat_o = ram_rdata_i;
endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter: a bench-side RAM, a cycle model of the arbitration
// rules checked every cycle, and hand-computed expectations for the directed scenarios.
module tb_vga_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          vga_req_i;
  logic [AW-1:0] vga_adr_i;
  logic          vga_gnt_o;
  logic [DW-1:0] vga_dat_o;
  logic          vga_vld_o;
  logic          ram_cs_o, ram_we_o;
  logic [AW-1:0] ram_adr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;

  vga_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .vga_req_i(vga_req_i), .vga_adr_i(vga_adr_i), .vga_gnt_o(vga_gnt_o),
    .vga_dat_o(vga_dat_o), .vga_vld_o(vga_vld_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Bench-side 2K x 8 RAM with registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs_o) begin
      if (ram_we_o) mem[ram_adr_o] <= ram_wdata_o;
      ram_rdata_i <= mem[ram_adr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model of the arbitration rules, kept as plain integers and a byte array.
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  bit            m_ack = 1'b0, m_ack_rd = 1'b0, m_vld = 1'b0;
  int            m_loss = 0;
  logic [DW-1:0] m_cpu_dat = '0, m_vga_dat = '0;

  always @(negedge clk) begin
    bit pend, cw, vw;
    if (run) begin
      pend = wb_cyc_i && wb_stb_i && !m_ack;
      cw   = rst_n && pend && (!vga_req_i || m_loss >= MAX_WAIT);
      vw   = rst_n && vga_req_i && !cw;
      chk("m_vga_gnt", 32'(vga_gnt_o), 32'(vw));
      chk("m_ram_cs", 32'(ram_cs_o), 32'(cw || vw));
      chk("m_ram_we", 32'(ram_we_o), 32'(cw && wb_we_i));
      if (cw || vw) chk("m_ram_adr", 32'(ram_adr_o), 32'(cw ? wb_adr_i : vga_adr_i));
      chk("m_ram_wdata", 32'(ram_wdata_o), 32'(wb_dat_i));
      chk("m_ack", 32'(wb_ack_o), 32'(m_ack));
      chk("m_vld", 32'(vga_vld_o), 32'(m_vld));
      if (m_ack && m_ack_rd) chk("m_cpu_dat", 32'(wb_dat_o), 32'(m_cpu_dat));
      if (m_vld) chk("m_vga_dat", 32'(vga_dat_o), 32'(m_vga_dat));
      if (!rst_n) begin
        m_ack = 1'b0; m_vld = 1'b0; m_loss = 0;
      end else begin
        if (cw) begin
          m_ack_rd = !wb_we_i;
          if (wb_we_i) exp_mem[wb_adr_i] = wb_dat_i;
          else         m_cpu_dat = exp_mem[wb_adr_i];
        end
        if (vw) m_vga_dat = exp_mem[vga_adr_i];
        if (pend && !cw) m_loss = (m_loss < MAX_WAIT) ? m_loss + 1 : m_loss;
        else             m_loss = 0;
        m_ack = cw;
        m_vld = vw;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; vga_req_i = 1'b0;
    end
  endtask

  logic [DW-1:0] font_tbl [0:3];

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a] = '0;
      exp_mem[a] = '0;
    end
    font_tbl[0] = 8'h5A; font_tbl[1] = 8'h65; font_tbl[2] = 8'h74; font_tbl[3] = 8'h20;
    for (int a = 0; a < 4; a++) begin
      mem[a] = font_tbl[a];
      exp_mem[a] = font_tbl[a];
    end
    ram_rdata_i = '0;
    rst_n = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; vga_req_i = 1'b1; vga_adr_i = '0;

    // 1: reset with both requesters active
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      run = 1'b1;
      @(negedge clk);
      chk("rst_cs", 32'(ram_cs_o), 32'd0);
      chk("rst_ack", 32'(wb_ack_o), 32'd0);
      chk("rst_vld", 32'(vga_vld_o), 32'd0);
    end
    next_cycle();
    rst_n = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; vga_req_i = 1'b0;
    idle(1);

    // 2: write 0x41 to 0x005, then read it back
    next_cycle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 11'h005; wb_dat_i = 8'h41;
    @(negedge clk);
    chk("wr_we", 32'(ram_we_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("wr_ack", 32'(wb_ack_o), 32'd1);
    next_cycle();
    wb_we_i = 1'b0; wb_dat_i = 8'h00;
    @(negedge clk);
    chk("rd_cs", 32'(ram_cs_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("rd_ack", 32'(wb_ack_o), 32'd1);
    chk("rd_dat", 32'(wb_dat_o), 32'h41);
    idle(2);

    // 3: VGA streams addresses 0..3
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      vga_req_i = (i < 4);
      vga_adr_i = AW'(i);
      @(negedge clk);
      if (i < 4) chk("vga_gnt", 32'(vga_gnt_o), 32'd1);
      if (i > 0) begin
        chk("vga_vld", 32'(vga_vld_o), 32'd1);
        chk("vga_dat", 32'(vga_dat_o), 32'(font_tbl[i-1]));
      end
    end
    idle(2);

    // 4: starvation guard forces the CPU slot in cycle 4
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 0) begin
        vga_req_i = 1'b1; vga_adr_i = 11'h004;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 11'h005;
      end
      @(negedge clk);
      if (i < 4) chk("starve_vga_gnt", 32'(vga_gnt_o), 32'd1);
      if (i == 4) begin
        chk("starve_cpu_slot", 32'(vga_gnt_o), 32'd0);
        chk("starve_adr", 32'(ram_adr_o), 32'h005);
      end
      if (i == 5) begin
        chk("starve_ack", 32'(wb_ack_o), 32'd1);
        chk("starve_dat", 32'(wb_dat_o), 32'h41);
      end
    end
    idle(2);

    // 5: CPU write to 0x010 then VGA fetch of the same address
    next_cycle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 11'h010; wb_dat_i = 8'h5A;
    next_cycle();
    vga_req_i = 1'b1; vga_adr_i = 11'h010;
    @(negedge clk);
    chk("raw_vga_gnt", 32'(vga_gnt_o), 32'd1);
    next_cycle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; vga_req_i = 1'b0;
    @(negedge clk);
    chk("raw_vld", 32'(vga_vld_o), 32'd1);
    chk("raw_dat", 32'(vga_dat_o), 32'h5A);
    idle(2);

    // 6a: held strobe gives grants on even cycles, acks on odd
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 0) begin
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 11'h001;
      end
      @(negedge clk);
      chk("burst_cs", 32'(ram_cs_o), 32'((i % 2) == 0));
      chk("burst_ack", 32'(wb_ack_o), 32'((i % 2) == 1));
    end
    idle(2);

    // 6b: reset in cycle 2 drops the grant and the following ack
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 0) begin
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 11'h002;
      end
      if (i == 2) rst_n = 1'b0;
      if (i == 3) rst_n = 1'b1;
      @(negedge clk);
      if (i == 0) chk("rbur_cs0", 32'(ram_cs_o), 32'd1);
      if (i == 1) chk("rbur_ack1", 32'(wb_ack_o), 32'd1);
      if (i == 2) chk("rbur_cs2", 32'(ram_cs_o), 32'd0);
      if (i == 3) begin
        chk("rbur_ack3", 32'(wb_ack_o), 32'd0);
        chk("rbur_wait", 32'(dut.r_wait_cnt), 32'd0);
        chk("rbur_cs3", 32'(ram_cs_o), 32'd1);
      end
      if (i == 4) chk("rbur_ack4", 32'(wb_ack_o), 32'd1);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
